div_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the ALU's non-restoring divide datapath. Executes RISC-V DIV/DIVU/REM/REMU using STEPS non-restoring steps per clock instead of the 32-level combinational array.
- Sits between the execute-stage issue logic and writeback. Uses a valid/ready handshake on both sides and carries a writeback tag.
- Resolves divide-by-zero and signed overflow without iterating.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/div_step.sv | 24 ++
 rtl/div_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types and constants for the sequential divider.
package alu_pkg;

    localparam int DIV_W = 32;
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFFFFFF;
    localparam logic [DIV_W-1:0] DIV_OVF_Q  = 32'h80000000;

    // Encoding matches funct3[1:0] of the RISC-V M-extension divide ops.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Two's-complement negation, modulo 2^32.
    function automatic logic [DIV_W-1:0] neg_w(input logic [DIV_W-1:0] x);
        return (~x) + 1'b1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring divide step.
// The accumulator carries one guard bit above the data width so that
// unsigned divisors of 2^31 and above cannot overflow the partial remainder.
module div_step
    import alu_pkg::*;
(
    input  logic [DIV_W:0] a,
    input  logic [DIV_W:0] d,
    input  logic           in_bit,
    output logic [DIV_W:0] a_next,
    output logic           q_bit
);

    logic [DIV_W:0] shift;

    // Shift in the next dividend bit, then add or subtract depending on the
    // sign of the current partial remainder.
    always_comb begin
        shift  = {a[DIV_W-1:0], in_bit};
        a_next = a[DIV_W] ? (shift + d) : (shift - d);
        q_bit  = ~a_next[DIV_W];
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle non-restoring divide sequencer for DIV/DIVU/REM/REMU.
// STEPS chained steps are evaluated per clock; divide-by-zero and signed
// overflow are resolved at accept without iterating.
module div_seq_ctrl
    import alu_pkg::*;
#(
    parameter int STEPS = 1,
    parameter int TAG_W = 5
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [1:0]       iOp,
    input  logic [31:0]      iDividend,
    input  logic [31:0]      iDivisor,
    input  logic [TAG_W-1:0] iTag,
    input  logic             iFlush,
    output logic             oValid,
    input  logic             iReady,
    output logic [31:0]      oResult,
    output logic [TAG_W-1:0] oTag,
    output logic             oBusy
);

    div_state_e         state_reg;
    div_op_e            op_reg;
    logic               sd_reg;
    logic               sv_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [TAG_W-1:0]   otag_reg;
    logic [DIV_W:0]     a_reg;
    logic [DIV_W-1:0]   q_reg;
    logic [DIV_W-1:0]   dvs_reg;
    logic [5:0]         cnt_reg;
    logic [5:0]         cnt_next;
    logic [DIV_W-1:0]   result_reg;
    logic               valid_reg;

    // Request decode on the raw operands.
    div_op_e            op_in;
    logic               in_signed;
    logic               in_rem;
    logic               in_sd;
    logic               in_sv;
    logic [DIV_W-1:0]   dvd_mag;
    logic [DIV_W-1:0]   dvs_mag;
    logic               div_zero;
    logic               div_ovf;
    logic [DIV_W-1:0]   special_result;

    // Post-iteration correction values.
    logic [DIV_W-1:0]   r_mag;
    logic [DIV_W-1:0]   q_fix;
    logic [DIV_W-1:0]   r_fix;
    logic [DIV_W-1:0]   fix_result;

    // Step chain: element 0 is the registered state, element STEPS the
    // value written back at the end of a CALC cycle.
    logic [DIV_W:0]     a_chain [STEPS+1];
    logic [DIV_W-1:0]   q_chain [STEPS+1];
    logic [STEPS-1:0]   qbit;

    assign op_in     = div_op_e'(iOp);
    assign in_signed = (op_in == DIV) || (op_in == REM);
    assign in_rem    = (op_in == REM) || (op_in == REMU);
    assign in_sd     = in_signed && iDividend[DIV_W-1];
    assign in_sv     = in_signed && iDivisor[DIV_W-1];
    assign dvd_mag   = in_sd ? neg_w(iDividend) : iDividend;
    assign dvs_mag   = in_sv ? neg_w(iDivisor) : iDivisor;
    assign div_zero  = (iDivisor == '0);
    assign div_ovf   = in_signed && (iDividend == DIV_OVF_Q) && (iDivisor == DIV_ZERO_Q);

    // Divide-by-zero wins over overflow; both finish straight from accept.
    always_comb begin
        if (div_zero) begin
            special_result = in_rem ? iDividend : DIV_ZERO_Q;
        end else begin
            special_result = in_rem ? '0 : DIV_OVF_Q;
        end
    end

    assign a_chain[0] = a_reg;
    assign q_chain[0] = q_reg;

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
            div_step u_step (
                .a      (a_chain[gi]),
                .d      ({1'b0, dvs_reg}),
                .in_bit (q_chain[gi][DIV_W-1]),
                .a_next (a_chain[gi+1]),
                .q_bit  (qbit[gi])
            );
            assign q_chain[gi+1] = {q_chain[gi][DIV_W-2:0], qbit[gi]};
        end
    endgenerate

    assign cnt_next = cnt_reg + 6'(STEPS);

    // Restore a negative final remainder, then apply the operand signs.
    always_comb begin
        r_mag      = a_reg[DIV_W] ? (a_reg[DIV_W-1:0] + dvs_reg) : a_reg[DIV_W-1:0];
        q_fix      = (sd_reg ^ sv_reg) ? neg_w(q_reg) : q_reg;
        r_fix      = sd_reg ? neg_w(r_mag) : r_mag;
        fix_result = ((op_reg == REM) || (op_reg == REMU)) ? r_fix : q_fix;
    end

    // Sequencer FSM with registered result, tag and valid.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_reg  <= IDLE;
            op_reg     <= DIV;
            sd_reg     <= 1'b0;
            sv_reg     <= 1'b0;
            tag_reg    <= '0;
            otag_reg   <= '0;
            a_reg      <= '0;
            q_reg      <= '0;
            dvs_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (iFlush) begin
            // Abort wins over accept and over the result handshake.
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (iValid) begin
                        op_reg  <= op_in;
                        tag_reg <= iTag;
                        sd_reg  <= in_sd;
                        sv_reg  <= in_sv;
                        dvs_reg <= dvs_mag;
                        a_reg   <= '0;
                        q_reg   <= dvd_mag;
                        cnt_reg <= '0;
                        if (div_zero || div_ovf) begin
                            result_reg <= special_result;
                            otag_reg   <= iTag;
                            valid_reg  <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            state_reg  <= CALC;
                        end
                    end
                end
                CALC: begin
                    a_reg   <= a_chain[STEPS];
                    q_reg   <= q_chain[STEPS];
                    cnt_reg <= cnt_next;
                    if (cnt_next == 6'd32) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    result_reg <= fix_result;
                    otag_reg   <= tag_reg;
                    valid_reg  <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    if (iReady) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign oReady  = (state_reg == IDLE);
    assign oBusy   = (state_reg != IDLE);
    assign oValid  = valid_reg;
    assign oResult = result_reg;
    assign oTag    = otag_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and randomized checks of div_seq_ctrl at STEPS=1 (index 0) and
// STEPS=4 (index 1) against an arithmetic reference model.
module tb_div_seq_ctrl;

    localparam int STEPS_A = 1;
    localparam int STEPS_B = 4;

    logic        iClk;
    logic        rst_n;
    logic        valid_i [2];
    logic [1:0]  op_i    [2];
    logic [31:0] dvd_i   [2];
    logic [31:0] dvs_i   [2];
    logic [4:0]  tag_i   [2];
    logic        flush_i [2];
    logic        rdy_i   [2];
    logic        ready_o [2];
    logic        valid_o [2];
    logic        busy_o  [2];
    logic [31:0] res_o   [2];
    logic [4:0]  tag_o   [2];

    int n_assert = 0;
    int n_fail   = 0;

    div_seq_ctrl #(.STEPS(STEPS_A), .TAG_W(5)) u_dut_a (
        .iClk(iClk), .iRst_n(rst_n), .iValid(valid_i[0]), .oReady(ready_o[0]),
        .iOp(op_i[0]), .iDividend(dvd_i[0]), .iDivisor(dvs_i[0]), .iTag(tag_i[0]),
        .iFlush(flush_i[0]), .oValid(valid_o[0]), .iReady(rdy_i[0]),
        .oResult(res_o[0]), .oTag(tag_o[0]), .oBusy(busy_o[0])
    );

    div_seq_ctrl #(.STEPS(STEPS_B), .TAG_W(5)) u_dut_b (
        .iClk(iClk), .iRst_n(rst_n), .iValid(valid_i[1]), .oReady(ready_o[1]),
        .iOp(op_i[1]), .iDividend(dvd_i[1]), .iDivisor(dvs_i[1]), .iTag(tag_i[1]),
        .iFlush(flush_i[1]), .oValid(valid_o[1]), .iReady(rdy_i[1]),
        .oResult(res_o[1]), .oTag(tag_o[1]), .oBusy(busy_o[1])
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Reference model: true quotient/remainder from integer arithmetic,
    // with the RISC-V results for divide-by-zero and signed overflow.
    function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (op[0] == 1'b0) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                q = 32'h80000000;
                r = 32'd0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (op[0] == 1'b0 && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    // Latency counts edges starting with the accept edge (which is edge 1).
    task automatic wait_valid(input int idx, output int lat);
        lat = 1;
        while (valid_o[idx] !== 1'b1 && lat < 200) begin
            @(posedge iClk);
            #1;
            lat++;
        end
    endtask

    // Called 1 time unit after an edge with the DUT idle; completes the handshake.
    task automatic do_op(input int idx, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input string nm);
        int lat;
        int steps;
        int exp_lat;
        logic [31:0] exp;
        steps   = (idx == 0) ? STEPS_A : STEPS_B;
        exp     = golden(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : (32 / steps + 2);
        chk($sformatf("%s ready", nm), 32'(ready_o[idx]), 32'd1);
        valid_i[idx] = 1'b1;
        op_i[idx]    = op;
        dvd_i[idx]   = a;
        dvs_i[idx]   = b;
        tag_i[idx]   = tag;
        @(posedge iClk);
        #1;
        valid_i[idx] = 1'b0;
        wait_valid(idx, lat);
        chk($sformatf("%s latency", nm), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s result", nm), res_o[idx], exp);
        chk($sformatf("%s tag", nm), 32'(tag_o[idx]), 32'(tag));
        $display("txn %s: dut%0d op=%0d a=%h b=%h -> %h (exp %h) lat=%0d",
                 nm, idx, op, a, b, res_o[idx], exp, lat);
        @(posedge iClk);
        #1;
        chk($sformatf("%s handshake", nm), 32'(valid_o[idx]), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int sel;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_i[i] = 1'b0; op_i[i] = 2'b00; dvd_i[i] = '0; dvs_i[i] = '0;
            tag_i[i] = '0; flush_i[i] = 1'b0; rdy_i[i] = 1'b1;
        end
        repeat (3) @(posedge iClk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset ready%0d", i), 32'(ready_o[i]), 32'd1);
            chk($sformatf("reset valid%0d", i), 32'(valid_o[i]), 32'd0);
            chk($sformatf("reset busy%0d", i), 32'(busy_o[i]), 32'd0);
            chk($sformatf("reset result%0d", i), res_o[i], 32'd0);
            chk($sformatf("reset tag%0d", i), 32'(tag_o[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge iClk);
        #1;

        // Directed operand cases at STEPS=1.
        do_op(0, 2'b01, 32'd100, 32'd7, 5'd3, "divu_100_7");
        do_op(0, 2'b11, 32'd100, 32'd7, 5'd3, "remu_100_7");
        do_op(0, 2'b00, -32'sd7, 32'd2, 5'd1, "div_m7_2");
        do_op(0, 2'b10, -32'sd7, 32'd2, 5'd2, "rem_m7_2");
        do_op(0, 2'b10, 32'd7, -32'sd2, 5'd5, "rem_7_m2");
        do_op(0, 2'b00, 32'd5, 32'd0, 5'd8, "div_by_zero");
        do_op(0, 2'b10, 32'd5, 32'd0, 5'd9, "rem_by_zero");
        do_op(0, 2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd10, "div_ovf");
        do_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd11, "rem_ovf");
        do_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, "divu_max_max");
        do_op(0, 2'b11, 32'hFFFFFFFE, 32'h80000001, 5'd13, "remu_big_div");
        do_op(0, 2'b00, 32'h80000000, 32'd3, 5'd14, "div_minint_3");

        // Backpressure: result held in DONE, a waiting request is not taken.
        rdy_i[0] = 1'b0; valid_i[0] = 1'b1; op_i[0] = 2'b01;
        dvd_i[0] = 32'd1000; dvs_i[0] = 32'd10; tag_i[0] = 5'd9;
        @(posedge iClk);
        #1;
        dvd_i[0] = 32'd50; dvs_i[0] = 32'd5; tag_i[0] = 5'd4;
        wait_valid(0, lat);
        chk("bp latency", 32'(lat), 32'(32 / STEPS_A + 2));
        for (int k = 0; k < 10; k++) begin
            chk("bp valid held", 32'(valid_o[0]), 32'd1);
            chk("bp result held", res_o[0], 32'd100);
            chk("bp tag held", 32'(tag_o[0]), 32'd9);
            chk("bp not ready", 32'(ready_o[0]), 32'd0);
            @(posedge iClk);
            #1;
        end
        $display("txn backpressure: dut0 divu 1000/10 held 10 cycles -> %h", res_o[0]);
        rdy_i[0] = 1'b1;
        @(posedge iClk);
        #1;
        chk("bp release valid", 32'(valid_o[0]), 32'd0);
        chk("bp release ready", 32'(ready_o[0]), 32'd1);
        chk("bp no accept in done", 32'(busy_o[0]), 32'd0);
        @(posedge iClk);
        #1;
        valid_i[0] = 1'b0;
        chk("bp next accepted", 32'(busy_o[0]), 32'd1);
        wait_valid(0, lat);
        chk("bp next latency", 32'(lat), 32'(32 / STEPS_A + 2));
        chk("bp next result", res_o[0], 32'd10);
        chk("bp next tag", 32'(tag_o[0]), 32'd4);
        $display("txn bp_next: dut0 divu 50/5 -> %h lat=%0d", res_o[0], lat);
        @(posedge iClk);
        #1;

        // Flush during CALC cycle 10, then an immediate new request.
        valid_i[0] = 1'b1; op_i[0] = 2'b01; dvd_i[0] = 32'd12345; dvs_i[0] = 32'd3;
        tag_i[0] = 5'd6;
        @(posedge iClk);
        #1;
        valid_i[0] = 1'b0;
        repeat (9) @(posedge iClk);
        #1;
        flush_i[0] = 1'b1;
        @(posedge iClk);
        #1;
        flush_i[0] = 1'b0;
        chk("flush valid", 32'(valid_o[0]), 32'd0);
        chk("flush busy", 32'(busy_o[0]), 32'd0);
        chk("flush ready", 32'(ready_o[0]), 32'd1);
        chk("flush result kept", res_o[0], 32'd10);
        $display("txn flush: dut0 divu 12345/3 aborted");
        do_op(0, 2'b01, 32'hFFFFFFFF, 32'd1, 5'd11, "after_flush");

        // A request presented together with flush is ignored.
        valid_i[0] = 1'b1; flush_i[0] = 1'b1; op_i[0] = 2'b01;
        dvd_i[0] = 32'd9; dvs_i[0] = 32'd3;
        @(posedge iClk);
        #1;
        valid_i[0] = 1'b0; flush_i[0] = 1'b0;
        chk("flush+valid busy", 32'(busy_o[0]), 32'd0);
        chk("flush+valid ready", 32'(ready_o[0]), 32'd1);
        $display("txn flush_with_request: dut0 request dropped");

        // Reset in the middle of CALC.
        valid_i[0] = 1'b1; op_i[0] = 2'b01; dvd_i[0] = 32'd77; dvs_i[0] = 32'd7;
        tag_i[0] = 5'd7;
        @(posedge iClk);
        #1;
        valid_i[0] = 1'b0;
        repeat (5) @(posedge iClk);
        #1;
        rst_n = 1'b0;
        @(posedge iClk);
        #1;
        rst_n = 1'b1;
        chk("midrst ready", 32'(ready_o[0]), 32'd1);
        chk("midrst valid", 32'(valid_o[0]), 32'd0);
        chk("midrst busy", 32'(busy_o[0]), 32'd0);
        chk("midrst result", res_o[0], 32'd0);
        chk("midrst tag", 32'(tag_o[0]), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge iClk);
            #1;
            if (valid_o[0] === 1'b1) seen++;
        end
        chk("midrst no result", 32'(seen), 32'd0);
        $display("txn reset_mid_calc: dut0 divu 77/7 discarded");

        // Randomized ops, mostly at STEPS=4, a few at STEPS=1.
        for (int n = 0; n < 48; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h80000000;
                4: rb = -32'($urandom_range(1, 15));
                5: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            do_op((n < 40) ? 1 : 0, rop, ra, rb, 5'($urandom_range(0, 31)),
                  $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
